// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
//   Shared definitions for the note sequencer:
//     - pattern width and the blank pattern
//     - LFSR feedback taps and the single-step LFSR function
//     - sequencer state encoding
//     - pattern shaping by difficulty level
// -----------------------------------------------------------------------------
package note_pkg;

    localparam int          PAT_W     = 4;
    localparam logic [3:0]  PAT_BLANK = 4'b0000;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // One Galois step, shifting right; taps fold in when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        if (v[0]) begin
            r = (v >> 1) ^ LFSR_TAPS;
        end else begin
            r = v >> 1;
        end
        return r;
    endfunction

    // Number of set bits in a 4-bit lane mask.
    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    // Turns a freshly stepped LFSR value into a lane mask for the given level.
    // The result is never blank: an all-zero nibble falls back to one-hot.
    function automatic logic [3:0] shape_pattern(input logic [1:0]  level,
                                                 input logic [15:0] l);
        logic [3:0] onehot;
        logic [3:0] m;
        logic [3:0] rest;
        logic [3:0] r;
        onehot = 4'b0001 << l[1:0];
        m      = l[3:0];
        // rest is m with its lowest set bit removed; x & -x isolates the lowest bit.
        rest   = m & (m - 4'd1);
        case (level)
            2'd0: begin
                r = onehot;
            end
            2'd1: begin
                if (m == 4'd0) begin
                    r = onehot;
                end else if (popcount4(m) > 3'd2) begin
                    r = (m & (~m + 4'd1)) | (rest & (~rest + 4'd1));
                end else begin
                    r = m;
                end
            end
            default: begin
                if (m == 4'd0) begin
                    r = onehot;
                end else begin
                    r = m;
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/note_sequencer_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
//   16-bit Galois LFSR that advances only when asked to.
//   Ports:
//     CLOCK_25  in   system clock
//     reset     in   synchronous active-high reset; loads seed
//     load      in   reload seed (wins over step)
//     seed      in   16-bit seed value, must be nonzero
//     step      in   advance one LFSR step
//     value     out  current register contents
// -----------------------------------------------------------------------------
module lfsr16
    import note_pkg::*;
(
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // Next LFSR value: reload, advance, or hold.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (step) begin
            value_d = lfsr_next(value_q);
        end else begin
            value_d = value_q;
        end
    end

    // LFSR register.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            value_q <= seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//   Feeds lane-mask patterns to N_ROWS falling-note instances. Each row holds
//   its pattern steady until the instance signals (rising edge on req) that it
//   consumed it; the row is then refilled from an LFSR shaped by level.
//   After SONG_LEN consumed patterns, requesting rows are blanked instead.
//   Ports:
//     CLOCK_25      in   system clock
//     reset         in   synchronous active-high reset
//     start         in   begin/restart a song from IDLE or DONE
//     level         in   difficulty 0..3
//     req           in   per-row consumption strobe (rising edge counts)
//     command_out   out  row i pattern at [4i+3:4i]
//     busy          out  high while priming or running
//     song_done     out  high once the song has ended
//     notes_issued  out  patterns consumed this song (saturating)
// -----------------------------------------------------------------------------
module note_sequencer
    import note_pkg::*;
#(
    parameter int          N_ROWS   = 3,
    parameter int          SONG_LEN = 64,
    parameter logic [15:0] SEED     = 16'hACE1
)(
    input  logic                    CLOCK_25,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              level,
    input  logic [N_ROWS-1:0]       req,
    output logic [PAT_W*N_ROWS-1:0] command_out,
    output logic                    busy,
    output logic                    song_done,
    output logic [7:0]              notes_issued
);

    localparam int                ROW_W    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(N_ROWS - 1);
    localparam logic [N_ROWS-1:0] ROW_ONE  = N_ROWS'(1'b1);
    localparam logic [7:0]        SONG_END = 8'(SONG_LEN);

    seq_state_e                state_q, state_d;
    logic [PAT_W*N_ROWS-1:0]   cmd_q, cmd_d;
    logic [N_ROWS-1:0]         pending_q, pending_d;
    logic [N_ROWS-1:0]         req_q, req_d;
    logic [7:0]                count_q, count_d;
    logic [ROW_W-1:0]          prime_idx_q, prime_idx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      lfsr_load_s;
    logic                      lfsr_step_s;
    logic [15:0]               lfsr_value_s;
    logic [15:0]               lfsr_peek_s;
    logic [3:0]                new_pat_s;
    logic [N_ROWS-1:0]         edge_s;
    logic                      svc_valid_s;
    logic [N_ROWS-1:0]         svc_onehot_s;
    logic [ROW_W-1:0]          svc_idx_s;

    lfsr16 u_lfsr (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .load     (lfsr_load_s),
        .seed     (SEED),
        .step     (lfsr_step_s),
        .value    (lfsr_value_s)
    );

    // Candidate pattern, request edges and the lowest-index pending row.
    always_comb begin
        // The pattern is shaped from the value the LFSR will hold after this step.
        lfsr_peek_s  = lfsr_next(lfsr_value_s);
        new_pat_s    = shape_pattern(level, lfsr_peek_s);
        edge_s       = req & ~req_q;
        svc_valid_s  = |pending_q;
        svc_onehot_s = pending_q & (~pending_q + ROW_ONE);
        svc_idx_s    = {ROW_W{1'b0}};
        for (int i = 0; i < N_ROWS; i++) begin
            svc_idx_s = svc_idx_s | (svc_onehot_s[i] ? ROW_W'(i) : {ROW_W{1'b0}});
        end
    end

    // Sequencer next-state: priming, servicing pending rows, song end.
    // Service reads only registered pending bits, so a row's old pattern is
    // still visible on the edge after the one that latched its request.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        pending_d   = pending_q;
        req_d       = req;
        count_d     = count_q;
        prime_idx_d = prime_idx_q;
        lfsr_load_s = 1'b0;
        lfsr_step_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PRIME;
                    count_d     = 8'd0;
                    pending_d   = {N_ROWS{1'b0}};
                    prime_idx_d = {ROW_W{1'b0}};
                    lfsr_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PRIME: begin
                cmd_d[prime_idx_q*PAT_W +: PAT_W] = new_pat_s;
                lfsr_step_s = 1'b1;
                if (prime_idx_q == LAST_ROW) begin
                    state_d     = RUN;
                    prime_idx_d = {ROW_W{1'b0}};
                end else begin
                    prime_idx_d = prime_idx_q + ROW_W'(1);
                end
            end
            RUN: begin
                pending_d = (pending_q & ~svc_onehot_s) | edge_s;
                if (count_q == SONG_END) begin
                    // Song is complete: blank instead of issuing, no LFSR step.
                    state_d = DONE;
                    if (svc_valid_s) begin
                        cmd_d[svc_idx_s*PAT_W +: PAT_W] = PAT_BLANK;
                    end else begin
                        cmd_d = cmd_q;
                    end
                end else if (svc_valid_s) begin
                    cmd_d[svc_idx_s*PAT_W +: PAT_W] = new_pat_s;
                    lfsr_step_s = 1'b1;
                    count_d     = count_q + 8'd1;
                end else begin
                    count_d = count_q;
                end
            end
            DONE: begin
                if (start) begin
                    state_d     = PRIME;
                    count_d     = 8'd0;
                    pending_d   = {N_ROWS{1'b0}};
                    prime_idx_d = {ROW_W{1'b0}};
                    lfsr_load_s = 1'b1;
                end else begin
                    pending_d = (pending_q & ~svc_onehot_s) | edge_s;
                    if (svc_valid_s) begin
                        cmd_d[svc_idx_s*PAT_W +: PAT_W] = PAT_BLANK;
                    end else begin
                        cmd_d = cmd_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == PRIME) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Sequencer registers; reset overrides any in-flight service.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= {(PAT_W*N_ROWS){1'b0}};
            pending_q   <= {N_ROWS{1'b0}};
            req_q       <= {N_ROWS{1'b0}};
            count_q     <= 8'd0;
            prime_idx_q <= {ROW_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            pending_q   <= pending_d;
            req_q       <= req_d;
            count_q     <= count_d;
            prime_idx_q <= prime_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign command_out  = cmd_q;
    assign busy         = busy_q;
    assign song_done    = done_q;
    assign notes_issued = count_q;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

    localparam int          N_ROWS   = 3;
    localparam int          SONG_LEN = 12;
    localparam logic [15:0] SEED     = 16'hACE1;

    localparam int PH_IDLE = 0;
    localparam int PH_FILL = 1;
    localparam int PH_PLAY = 2;
    localparam int PH_END  = 3;

    logic                  CLOCK_25 = 1'b0;
    logic                  reset;
    logic                  start;
    logic [1:0]            level;
    logic [N_ROWS-1:0]     req;
    logic [4*N_ROWS-1:0]   command_out;
    logic                  busy;
    logic                  song_done;
    logic [7:0]            notes_issued;

    always #20 CLOCK_25 = ~CLOCK_25;

    note_sequencer #(
        .N_ROWS   (N_ROWS),
        .SONG_LEN (SONG_LEN),
        .SEED     (SEED)
    ) dut (
        .CLOCK_25     (CLOCK_25),
        .reset        (reset),
        .start        (start),
        .level        (level),
        .req          (req),
        .command_out  (command_out),
        .busy         (busy),
        .song_done    (song_done),
        .notes_issued (notes_issued)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int                m_phase;
    int                m_fill;
    int                m_count;
    logic [15:0]       m_lfsr;
    logic [3:0]        m_row  [N_ROWS];
    bit                m_pend [N_ROWS];
    logic [N_ROWS-1:0] m_req_prev;

    function automatic logic [3:0] model_shape(input int lvl, input logic [15:0] l);
        int         bits[$];
        logic [3:0] r;
        logic [1:0] low2;
        low2 = l[1:0];
        for (int i = 0; i < 4; i++) if (l[i]) bits.push_back(i);
        if (lvl == 0 || bits.size() == 0) return 4'b0001 << low2;
        if (lvl >= 2) return l[3:0];
        r = 4'b0000;
        for (int k = 0; k < bits.size() && k < 2; k++) r[bits[k]] = 1'b1;
        return r;
    endfunction

    task automatic model_gen(output logic [3:0] p);
        if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
        else           m_lfsr = m_lfsr >> 1;
        p = model_shape(int'(level), m_lfsr);
    endtask

    task automatic model_begin_song();
        m_phase = PH_FILL;
        m_fill  = 0;
        m_count = 0;
        m_lfsr  = SEED;
        for (int i = 0; i < N_ROWS; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_cycle();
        logic [N_ROWS-1:0] rise;
        logic [3:0]        p;
        int                sel;
        rise = req & ~m_req_prev;
        sel  = -1;
        for (int i = N_ROWS - 1; i >= 0; i--) if (m_pend[i]) sel = i;
        if (reset) begin
            m_phase = PH_IDLE;
            m_fill  = 0;
            m_count = 0;
            m_lfsr  = SEED;
            for (int i = 0; i < N_ROWS; i++) begin
                m_row[i]  = 4'h0;
                m_pend[i] = 1'b0;
            end
            m_req_prev = '0;
        end else begin
            case (m_phase)
                PH_IDLE: if (start) model_begin_song();
                PH_FILL: begin
                    model_gen(p);
                    m_row[m_fill] = p;
                    m_fill++;
                    if (m_fill == N_ROWS) m_phase = PH_PLAY;
                end
                PH_PLAY: begin
                    if (m_count == SONG_LEN) begin
                        m_phase = PH_END;
                        if (sel >= 0) m_row[sel] = 4'h0;
                    end else if (sel >= 0) begin
                        model_gen(p);
                        m_row[sel] = p;
                        m_count++;
                    end
                    if (sel >= 0) m_pend[sel] = 1'b0;
                    for (int i = 0; i < N_ROWS; i++) if (rise[i]) m_pend[i] = 1'b1;
                end
                default: begin
                    if (start) begin
                        model_begin_song();
                    end else begin
                        if (sel >= 0) begin
                            m_row[sel]  = 4'h0;
                            m_pend[sel] = 1'b0;
                        end
                        for (int i = 0; i < N_ROWS; i++) if (rise[i]) m_pend[i] = 1'b1;
                    end
                end
            endcase
            m_req_prev = req;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N_ROWS; i++)
            check_eq($sformatf("row%0d", i), 32'(command_out[4*i +: 4]), 32'(m_row[i]));
        check_eq("busy", 32'(busy), 32'(m_phase == PH_FILL || m_phase == PH_PLAY));
        check_eq("song_done", 32'(song_done), 32'(m_phase == PH_END));
        check_eq("notes_issued", 32'(notes_issued), 32'(m_count));
    endtask

    task automatic tick();
        @(posedge CLOCK_25);
        model_cycle();
        #1;
        compare_all();
    endtask

    task automatic restart();
        req   = '0;
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N_ROWS + 1; i++) tick();
    endtask

    task automatic pulse_row(input int r);
        req    = '0;
        req[r] = 1'b1;
        tick();
        req = '0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    logic [3:0] old_rows [N_ROWS];
    int         pc;
    int         maxpc;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        level = 2'd3;
        req   = '0;

        // Reset state.
        for (int i = 0; i < 3; i++) tick();
        check_eq("rst_cmd", 32'(command_out), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);

        // First song at level 3: seed ACE1 steps to E270, nibble 0 -> 4'h1.
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N_ROWS; i++) tick();
        check_eq("prime_row0", 32'(command_out[3:0]), 32'h1);
        check_eq("prime_busy", 32'(busy), 32'h1);

        // Simultaneous requests: rows refresh in index order, old values held.
        restart();
        level = 2'd2;
        tick();
        for (int i = 0; i < N_ROWS; i++) old_rows[i] = m_row[i];
        req = 3'b111;
        tick();
        req = '0;
        for (int i = 0; i < N_ROWS; i++)
            check_eq($sformatf("hold_a%0d", i), 32'(command_out[4*i +: 4]), 32'(old_rows[i]));
        tick();
        check_eq("hold_b1", 32'(command_out[7:4]), 32'(old_rows[1]));
        check_eq("hold_b2", 32'(command_out[11:8]), 32'(old_rows[2]));
        tick();
        check_eq("hold_c2", 32'(command_out[11:8]), 32'(old_rows[2]));
        tick();
        tick();
        check_eq("multi_notes", 32'(notes_issued), 32'd3);

        // Held request counts once; start during RUN is ignored.
        restart();
        req = 3'b001;
        for (int i = 0; i < 10; i++) tick();
        req = '0;
        tick();
        check_eq("held_notes", 32'(notes_issued), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("start_in_run_busy", 32'(busy), 32'h1);
        check_eq("start_in_run_notes", 32'(notes_issued), 32'd1);

        // Song end: count saturates, extra requests blank their rows.
        restart();
        for (int k = 0; k < SONG_LEN + 2; k++) pulse_row(k % N_ROWS);
        check_eq("end_notes", 32'(notes_issued), 32'(SONG_LEN));
        check_eq("end_done", 32'(song_done), 32'h1);
        check_eq("end_blank_a", 32'(command_out[4*(SONG_LEN % N_ROWS) +: 4]), 32'h0);
        check_eq("end_blank_b", 32'(command_out[4*((SONG_LEN + 1) % N_ROWS) +: 4]), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_busy", 32'(busy), 32'h1);
        check_eq("restart_notes", 32'(notes_issued), 32'h0);

        // Reset while rows 0 and 2 are pending: nothing gets serviced.
        restart();
        req = 3'b101;
        tick();
        req   = '0;
        reset = 1'b1;
        tick();
        check_eq("midrst_cmd", 32'(command_out), 32'h0);
        check_eq("midrst_notes", 32'(notes_issued), 32'h0);
        reset = 1'b0;
        tick();
        check_eq("midrst_idle_cmd", 32'(command_out), 32'h0);
        check_eq("midrst_idle_busy", 32'(busy), 32'h0);

        // Lane-count limits at levels 0 and 1 over 200 requests.
        level = 2'd0;
        restart();
        for (int k = 0; k < 200; k++) begin
            level = (k < 100) ? 2'd0 : 2'd1;
            maxpc = (k < 100) ? 1 : 2;
            if (m_phase != PH_PLAY) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                for (int i = 0; i < N_ROWS + 1; i++) tick();
            end
            pulse_row($urandom_range(0, N_ROWS - 1));
            if (m_phase == PH_PLAY && m_count < SONG_LEN) begin
                for (int i = 0; i < N_ROWS; i++) begin
                    pc = $countones(command_out[4*i +: 4]);
                    check_eq($sformatf("popcount_row%0d", i), 32'(pc >= 1 && pc <= maxpc), 32'h1);
                end
            end
        end

        // Free-running random traffic against the model.
        restart();
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < N_ROWS; i++)
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            if ((m_phase == PH_END || m_phase == PH_IDLE) && $urandom_range(0, 5) == 0)
                start = 1'b1;
            else if ($urandom_range(0, 39) == 0)
                start = 1'b1;
            else
                start = 1'b0;
            if ($urandom_range(0, 19) == 0) level = 2'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
